// File: rtl/life_8x8.sv
// Conway's Game of Life engine for an 8x8 LED matrix.
// Each request computes one generation, one cell per clock, then commits the frame atomically.
module life_8x8 #(
  parameter bit          WRAP       = 1'b1,
  parameter logic [63:0] INIT_FRAME = 64'h0000_0000_0007_0402
) (
  input  logic        i_CLK,
  input  logic        i_RST_n,
  input  logic        i_step,
  input  logic        i_seed_dv,
  input  logic [63:0] i_seed_data,
  output logic [63:0] o_frame,
  output logic        o_frame_valid,
  output logic        o_busy,
  output logic [15:0] o_gen,
  output logic        o_stable,
  output logic        o_empty
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] frame_reg;
  logic [63:0] next_reg;
  logic [5:0]  idx_reg;
  logic [15:0] gen_reg;
  logic        valid_reg;
  logic        stable_reg;
  logic        empty_reg;
  logic [63:0] live_next;

  // Neighbour lookup; off-grid cells read as dead unless the board is toroidal.
  function automatic logic cell_at(input logic [63:0] f, input int r, input int c);
    logic       on_grid;
    logic [5:0] bi;
    on_grid = (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
    bi      = 6'((((r + 8) % 8) * 8) + ((c + 8) % 8));
    return (WRAP || on_grid) && f[bi];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_cell
      logic [3:0] cnt;
      always_comb begin
        cnt = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              cnt = cnt + {3'd0, cell_at(frame_reg, (gi / 8) + dr, (gi % 8) + dc)};
            end
          end
        end
      end
      assign live_next[gi] = (cnt == 4'd3) | (frame_reg[gi] & (cnt == 4'd2));
    end
  endgenerate

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_step) state_next = CALC;
      CALC:    if (idx_reg == 6'd63) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A seed aborts any generation in flight.
    if (i_seed_dv) state_next = IDLE;
  end

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      frame_reg  <= INIT_FRAME;
      next_reg   <= 64'd0;
      idx_reg    <= 6'd0;
      gen_reg    <= 16'd0;
      valid_reg  <= 1'b0;
      stable_reg <= 1'b0;
      empty_reg  <= (INIT_FRAME == 64'd0);
    end else begin
      valid_reg <= 1'b0;
      if (i_seed_dv) begin
        frame_reg  <= i_seed_data;
        next_reg   <= 64'd0;
        idx_reg    <= 6'd0;
        gen_reg    <= 16'd0;
        stable_reg <= 1'b0;
        empty_reg  <= (i_seed_data == 64'd0);
        valid_reg  <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: idx_reg <= 6'd0;
          CALC: begin
            next_reg[idx_reg] <= live_next[idx_reg];
            idx_reg           <= idx_reg + 6'd1;
          end
          COMMIT: begin
            frame_reg  <= next_reg;
            stable_reg <= (next_reg == frame_reg);
            gen_reg    <= gen_reg + 16'd1;
            empty_reg  <= (next_reg == 64'd0);
            valid_reg  <= 1'b1;
          end
          default: idx_reg <= 6'd0;
        endcase
      end
    end
  end

  assign o_frame       = frame_reg;
  assign o_frame_valid = valid_reg;
  assign o_busy        = (state_reg == CALC) || (state_reg == COMMIT);
  assign o_gen         = gen_reg;
  assign o_stable      = stable_reg;
  assign o_empty       = empty_reg;

endmodule

// File: tb/tb_life_8x8.sv
// Directed bench for life_8x8: a toroidal and a bounded instance share one stimulus stream.
module tb_life_8x8;

  localparam logic [63:0] INIT    = 64'h0000_0000_0007_0402;
  localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000;
  localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
  localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, step, seed_dv;
  logic [63:0] seed_data;
  logic [63:0] frame_w, frame_n;
  logic        valid_w, valid_n, busy_w, busy_n, stable_w, stable_n, empty_w, empty_n;
  logic [15:0] gen_w, gen_n;

  life_8x8 #(.WRAP(1'b1), .INIT_FRAME(INIT)) dut_w (
    .i_CLK(clk), .i_RST_n(rst_n), .i_step(step), .i_seed_dv(seed_dv),
    .i_seed_data(seed_data), .o_frame(frame_w), .o_frame_valid(valid_w),
    .o_busy(busy_w), .o_gen(gen_w), .o_stable(stable_w), .o_empty(empty_w)
  );

  life_8x8 #(.WRAP(1'b0), .INIT_FRAME(INIT)) dut_n (
    .i_CLK(clk), .i_RST_n(rst_n), .i_step(step), .i_seed_dv(seed_dv),
    .i_seed_data(seed_data), .o_frame(frame_n), .o_frame_valid(valid_n),
    .o_busy(busy_n), .o_gen(gen_n), .o_stable(stable_n), .o_empty(empty_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_seed(input logic [63:0] d);
    @(negedge clk);
    seed_dv   = 1'b1;
    seed_data = d;
    @(negedge clk);
    seed_dv   = 1'b0;
  endtask

  // Pulses step for one edge, then counts cycles until the commit pulse appears.
  task automatic run_step(output int lat);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("busy_after_step", {63'd0, busy_w}, 64'd1);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (valid_w) break;
    end
  endtask

  typedef struct {
    string       name;
    logic [63:0] seed;
    logic [63:0] exp_w;
    logic [63:0] exp_n;
    logic        exp_stable;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    int pulses;

    vecs[0] = '{"blinker", BLINK_H, BLINK_V, BLINK_V, 1'b0};
    vecs[1] = '{"block",   BLOCK,   BLOCK,   BLOCK,   1'b1};
    vecs[2] = '{"edge83",  64'h83,  64'h0100_0000_0000_0101, 64'h0, 1'b0};
    vecs[3] = '{"single",  64'h1,   64'h0,   64'h0,   1'b0};
    vecs[4] = '{"empty",   64'h0,   64'h0,   64'h0,   1'b1};

    rst_n = 1'b0; step = 1'b0; seed_dv = 1'b0; seed_data = 64'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_frame", frame_w, INIT);
    check("rst_gen", {48'd0, gen_w}, 64'd0);
    check("rst_busy", {63'd0, busy_w}, 64'd0);
    check("rst_valid", {63'd0, valid_w}, 64'd0);
    check("rst_empty", {63'd0, empty_w}, 64'd0);
    $display("reset: frame=%h gen=%0d", frame_w, gen_w);

    for (int i = 0; i < 5; i++) begin
      do_seed(vecs[i].seed);
      check({vecs[i].name, "_seed_frame"}, frame_w, vecs[i].seed);
      check({vecs[i].name, "_seed_valid"}, {63'd0, valid_w}, 64'd1);
      run_step(lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd65);
      check({vecs[i].name, "_frame_wrap"}, frame_w, vecs[i].exp_w);
      check({vecs[i].name, "_frame_nowrap"}, frame_n, vecs[i].exp_n);
      check({vecs[i].name, "_valid_nowrap"}, {63'd0, valid_n}, 64'd1);
      check({vecs[i].name, "_gen"}, {48'd0, gen_w}, 64'd1);
      check({vecs[i].name, "_stable"}, {63'd0, stable_w}, {63'd0, vecs[i].exp_stable});
      check({vecs[i].name, "_empty_nowrap"}, {63'd0, empty_n}, {63'd0, (vecs[i].exp_n == 64'd0)});
      @(negedge clk);
      check({vecs[i].name, "_valid_drop"}, {63'd0, valid_w}, 64'd0);
      check({vecs[i].name, "_busy_drop"}, {63'd0, busy_w}, 64'd0);
      $display("vec %s: seed=%h wrap=%h nowrap=%h lat=%0d", vecs[i].name, vecs[i].seed, frame_w, frame_n, lat);
    end

    // Blinker returns to its original phase after two generations.
    do_seed(BLINK_H);
    run_step(lat);
    run_step(lat);
    check("blink2_frame", frame_w, BLINK_H);
    check("blink2_gen", {48'd0, gen_w}, 64'd2);
    check("blink2_stable", {63'd0, stable_w}, 64'd0);
    $display("blinker x2: frame=%h gen=%0d", frame_w, gen_w);

    // Re-seeding a still life clears stable and the generation count.
    do_seed(BLOCK);
    run_step(lat);
    check("block_stable_set", {63'd0, stable_w}, 64'd1);
    do_seed(BLOCK);
    check("reseed_stable", {63'd0, stable_w}, 64'd0);
    check("reseed_gen", {48'd0, gen_w}, 64'd0);
    $display("block reseed: stable=%0d gen=%0d", stable_w, gen_w);

    // Seed at cycle 30 of CALC aborts the generation.
    do_seed(BLINK_H);
    run_step(lat);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (29) @(negedge clk);
    seed_dv = 1'b1; seed_data = 64'hFF;
    @(negedge clk);
    seed_dv = 1'b0;
    check("abort_frame", frame_w, 64'hFF);
    check("abort_busy", {63'd0, busy_w}, 64'd0);
    check("abort_gen", {48'd0, gen_w}, 64'd0);
    pulses = 0;
    repeat (50) begin
      @(negedge clk);
      if (valid_w) pulses++;
    end
    check("abort_no_commit", 64'(pulses), 64'd0);
    check("abort_frame_hold", frame_w, 64'hFF);
    $display("abort: frame=%h gen=%0d pulses=%0d", frame_w, gen_w, pulses);

    // A step pulse during CALC is not queued.
    do_seed(BLINK_H);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (10) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    lat = 0;
    while (lat < 200 && !valid_w) begin
      @(negedge clk);
      lat++;
    end
    check("overlap_commit_seen", {63'd0, valid_w}, 64'd1);
    pulses = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid_w) pulses++;
    end
    check("overlap_no_extra", 64'(pulses), 64'd0);
    check("overlap_gen", {48'd0, gen_w}, 64'd1);
    $display("overlap: gen=%0d extra=%0d", gen_w, pulses);

    // Generation counter wrap, starting from a preloaded count.
    @(negedge clk);
    force dut_w.gen_reg = 16'hFFFF;
    @(negedge clk);
    release dut_w.gen_reg;
    run_step(lat);
    check("gen_wrap", {48'd0, gen_w}, 64'd0);
    $display("gen wrap: gen=%0d", gen_w);

    // Asynchronous reset in the middle of CALC.
    do_seed(BLOCK);
    run_step(lat);
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_frame", frame_w, INIT);
    check("arst_busy", {63'd0, busy_w}, 64'd0);
    check("arst_gen", {48'd0, gen_w}, 64'd0);
    check("arst_stable", {63'd0, stable_w}, 64'd0);
    check("arst_valid", {63'd0, valid_w}, 64'd0);
    $display("async reset: frame=%h busy=%0d gen=%0d", frame_w, busy_w, gen_w);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
